// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
//   state_t     - FSM state codes (also the value shown on the debug state port)
//   OP_*        - opcode constants recognised by the decoder
//   ctrl_out_t  - bundle of every control output produced by ctrl_outdec
//   op_legal()  - true when an opcode has a defined instruction flow
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal;
  } ctrl_out_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// ctrl_outdec: combinational state-to-output decode for multicycle_ctrl.
//   reset     in  - forces every output to 0 while the register is being reset
//   state     in  - current FSM state
//   op        in  - opcode, only used to flag an illegal opcode in DECODE
//   mem_ready in  - memory handshake: completion qualifies irwrite/pcwrite in
//                   FETCH and instr_done in MEMWR
//   ctl       out - all control outputs
// Handshake: a memory access (FETCH, MEMRD, MEMWR) is presented continuously
// and completes in the cycle mem_ready=1; all outputs that do not depend on
// mem_ready stay constant while it is low.
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_out_t  ctl
);

  always_comb begin
    ctl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctl.memread = 1'b1;
          ctl.alusrcb = 2'b01;
          // IR and PC capture only when the instruction word arrives.
          ctl.irwrite = mem_ready;
          ctl.pcwrite = mem_ready;
        end
        S_DECODE: begin
          ctl.alusrcb = 2'b11;
          ctl.illegal = !op_legal(op);
        end
        S_MEMADR, S_ADDIEX: begin
          ctl.alusrca = 1'b1;
          ctl.alusrcb = 2'b10;
        end
        S_MEMRD: begin
          ctl.memread = 1'b1;
          ctl.iord    = 1'b1;
        end
        S_MEMWB: begin
          ctl.regwrite   = 1'b1;
          ctl.memtoreg   = 1'b1;
          ctl.instr_done = 1'b1;
        end
        S_MEMWR: begin
          ctl.memwrite   = 1'b1;
          ctl.iord       = 1'b1;
          ctl.instr_done = mem_ready;
        end
        S_RTEXEC: begin
          ctl.alusrca = 1'b1;
          ctl.aluop   = 2'b10;
        end
        S_RTWB: begin
          ctl.regdst     = 1'b1;
          ctl.regwrite   = 1'b1;
          ctl.instr_done = 1'b1;
        end
        S_BEQ: begin
          // PC update is gated by the ALU zero flag in the datapath.
          ctl.alusrca     = 1'b1;
          ctl.aluop       = 2'b01;
          ctl.pcwritecond = 1'b1;
          ctl.pcsource    = 2'b01;
          ctl.instr_done  = 1'b1;
        end
        S_JUMP: begin
          ctl.pcwrite    = 1'b1;
          ctl.pcsource   = 2'b10;
          ctl.instr_done = 1'b1;
        end
        S_ADDIWB: begin
          ctl.regwrite   = 1'b1;
          ctl.instr_done = 1'b1;
        end
        default: ctl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style control FSM for a multicycle MIPS-like core.
//   clk, reset           in  - clock, synchronous active-high reset
//   op                   in  - instruction opcode
//   zero                 in  - ALU zero flag (consumed by the datapath's
//                              branch gating, not by this FSM)
//   mem_ready            in  - memory completes the pending access this cycle
//   pcwrite..alusrca     out - datapath enables/selects
//   alusrcb, pcsource    out - 2-bit mux selects
//   aluop1, aluop0       out - ALU-control class
//   instr_done, illegal  out - single-cycle pulses
//   state                out - current state code (debug)
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t    state_q, state_d;
  ctrl_out_t ctl;
  logic      unused_zero;

  assign unused_zero = zero;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_RTEXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC: state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  ctrl_outdec u_outdec (
    .reset     (reset),
    .state     (state_q),
    .op        (op),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  assign pcwrite     = ctl.pcwrite;
  assign pcwritecond = ctl.pcwritecond;
  assign iord        = ctl.iord;
  assign memread     = ctl.memread;
  assign memwrite    = ctl.memwrite;
  assign irwrite     = ctl.irwrite;
  assign memtoreg    = ctl.memtoreg;
  assign regdst      = ctl.regdst;
  assign regwrite    = ctl.regwrite;
  assign alusrca     = ctl.alusrca;
  assign alusrcb     = ctl.alusrcb;
  assign pcsource    = ctl.pcsource;
  assign aluop1      = ctl.aluop[1];
  assign aluop0      = ctl.aluop[0];
  assign instr_done  = ctl.instr_done;
  assign illegal     = ctl.illegal;
  assign state       = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port op, input, 6 bits: opcode field from the instruction register.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current read/write this cycle.
REQ-006 SHALL have ports pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca, outputs, 1 bit each: datapath enables and selects.
REQ-007 SHALL have ports alusrcb and pcsource, outputs, 2 bits each: ALU B mux and PC mux selects.
REQ-008 SHALL have ports aluop1 and aluop0, outputs, 1 bit each: ALU-control class, driven straight into alucont (00 add, 01 sub, 1x funct-decoded).
REQ-009 SHALL have ports instr_done and illegal, outputs, 1 bit each: single-cycle pulses.
REQ-010 SHALL have port state, output, 4 bits: current state code for debug.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH.
REQ-012 FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite=pcwrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-013 DECODE: alusrca=0, alusrcb=11, aluop=00; next state from op.
REQ-014 Opcode routing: 000000 -> RTEXEC; 100011 (lw) and 101011 (sw) -> MEMADR; 000100 -> BEQ; 000010 -> JUMP; 001000 -> ADDIEX; any other op -> FETCH with illegal=1 for that one cycle.
REQ-015 MEMADR: alusrca=1, alusrcb=10, aluop=00; go to MEMRD if op=lw, else MEMWR.
REQ-016 MEMRD: memread=1, iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1; go to FETCH.
REQ-018 MEMWR: memwrite=1, iord=1; hold until mem_ready=1; on that cycle instr_done=1 and go to FETCH.
REQ-019 RTEXEC: alusrca=1, alusrcb=00, aluop=10; go to RTWB. The funct field (including NOR and compare functs) is resolved by alucont, not here.
REQ-020 RTWB: regdst=1, regwrite=1, memtoreg=0, instr_done=1; go to FETCH.
REQ-021 BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, instr_done=1; go to FETCH. The datapath gates the PC update with zero; this block does not use zero for sequencing.
REQ-022 JUMP: pcwrite=1, pcsource=10, instr_done=1; go to FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10, aluop=00; go to ADDIWB.
REQ-024 ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1; go to FETCH.
REQ-025 Any output not listed for a state SHALL be 0 in that state.
REQ-026 Latency with mem_ready tied high SHALL be: lw 5 cycles, sw/R-type/addi 4 cycles, beq/j 3 cycles. Each wait cycle with mem_ready=0 adds exactly one cycle.
REQ-027 memread and memwrite SHALL never be high in the same cycle.
REQ-028 While a memory access waits on mem_ready, every output SHALL stay stable.

Reset
REQ-029 While reset=1, state SHALL load FETCH and every control output, instr_done and illegal SHALL be forced to 0.
REQ-030 Reset asserted in any state, including during a memory wait, SHALL abort the instruction with no register or PC write in the reset cycle.
REQ-031 The first cycle after reset deasserts SHALL be FETCH with memread=1.

Structure
REQ-032 The state codes and opcode constants (R-type, lw, sw, beq, j, addi) SHALL live in shared package ctrl_pkg.
REQ-033 The state-to-output decode SHALL be one combinational sub-module, ctrl_outdec. The state register and next-state logic SHALL stay in multicycle_ctrl.

Verification
REQ-034 Reset, then R-type op=000000 with mem_ready=1 -> states 0,1,6,7,0; aluop=10 in RTEXEC; regwrite=regdst=1 and instr_done=1 in RTWB.
REQ-035 lw op=100011 with mem_ready low for 2 cycles in MEMRD -> MEMRD lasts 3 cycles with outputs stable; MEMWB has memtoreg=1; total 7 cycles.
REQ-036 sw op=101011 -> MEMWR has memwrite=1, iord=1 and instr_done=1 on the mem_ready cycle; memread=0 throughout MEMWR.
REQ-037 beq op=000100 -> BEQ has pcwritecond=1, pcsource=01, aluop=01; 3 cycles; j op=000010 -> pcwrite=1, pcsource=10.
REQ-038 op=111111 -> DECODE asserts illegal for one cycle, next state FETCH, no regwrite/memwrite at any point.
REQ-039 Reset asserted in MEMRD while mem_ready=0 -> next state FETCH; all outputs 0 during reset; memread=1 on the first cycle after release.
